// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for a 5-stage RV32I core: load-use stalls,
// redirect flushes, data-memory freeze, memory timeout trap, perf counters.
// Ports: clk/reset; ID/EX/MEM hazard inputs; PC/IF-ID/ID-EX/EX-MEM controls;
//        sticky mem_timeout; saturating stall_cnt and flush_cnt.
// Control outputs are combinational from state and inputs (zero latency);
// counters and trap flag are registered.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_inst,
    input  logic             id_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TRAP     = 2'd2
    } state_t;

    state_t          state;
    logic            redirect_pend;
    logic [WC_W-1:0] wait_cnt;

    logic rs1_used;
    logic rs2_used;
    logic load_use;
    logic redir;

    // Which source register fields the ID instruction actually reads.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (id_inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: rs1_used = 1'b1;
            7'b0110011, 7'b0100011, 7'b1100011: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    assign load_use = id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                      ((rs1_used && (id_inst[19:15] == ex_rd)) ||
                       (rs2_used && (id_inst[24:20] == ex_rd)));

    // A redirect seen during a freeze is replayed once the freeze lifts.
    assign redir = ex_redirect || redirect_pend;

    // Priority: trap > freeze > flush > load-use stall > normal.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_hold  = 1'b0;
        if (state == TRAP || mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
        end else if (redir) begin
            // ID instruction is squashed, so a coincident load-use is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            redirect_pend <= 1'b0;
            wait_cnt      <= '0;
            mem_timeout   <= 1'b0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
        end else if (state != TRAP) begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_busy) begin
                        if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                            state       <= TRAP;
                            mem_timeout <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + WC_W'(1);
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                default: state <= TRAP;
            endcase

            if (mem_busy) begin
                if (ex_redirect) redirect_pend <= 1'b1;
            end else begin
                // Not frozen: any pending redirect is being flushed now.
                redirect_pend <= 1'b0;
            end

            if (!pc_write && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_id_flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      id_inst;
    logic             id_valid;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_redirect;
    logic             mem_busy;
    logic             pc_write, if_id_write, id_ex_bubble;
    logic             if_id_flush, id_ex_flush, ex_mem_hold, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_inst(id_inst), .id_valid(id_valid),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy), .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_hold(ex_mem_hold),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]       ctl;   // pc_write,if_id_write,bubble,if_flush,ex_flush,hold,timeout
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: counts of events, not controller encoding.
    int m_busy_run;   // consecutive busy cycles seen so far
    bit m_trap, m_pend, m_to;
    int m_stall, m_flush;

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0010011, 7'b0110011,
                          7'b0100011, 7'b1100011, 7'b1100111};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, 5'd6, op};
    endfunction

    function automatic int sat_inc(input int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    // Drive one cycle of inputs, predict the cycle's outputs, advance model.
    task automatic step(input bit r, input logic [31:0] inst, input bit iv,
                        input bit mr, input logic [4:0] rd, input bit rdr,
                        input bit busy);
        bit   hz;
        bit   pcw, ifw, bub, fl, hold;
        exp_t e;
        reset = r; id_inst = inst; id_valid = iv; ex_mem_read = mr;
        ex_rd = rd; ex_redirect = rdr; mem_busy = busy;
        if (r) begin
            m_busy_run = 0; m_trap = 0; m_pend = 0; m_to = 0;
            m_stall = 0; m_flush = 0;
        end
        hz = iv && mr && (rd != 0) &&
             ((reads_rs1(inst[6:0]) && inst[19:15] == rd) ||
              (reads_rs2(inst[6:0]) && inst[24:20] == rd));
        pcw = 1; ifw = 1; bub = 0; fl = 0; hold = 0;
        e.stall = CNT_W'(m_stall);
        e.flush = CNT_W'(m_flush);
        if (m_trap || busy) begin
            pcw = 0; ifw = 0; hold = 1;
        end else if (rdr || m_pend) begin
            fl = 1;
        end else if (hz) begin
            pcw = 0; ifw = 0; bub = 1;
        end
        e.ctl = {pcw, ifw, bub, fl, fl, hold, m_to};
        sb.push_back(e);
        if (!r && !m_trap) begin
            if (busy) begin
                m_stall = sat_inc(m_stall);
                if (rdr) m_pend = 1;
                m_busy_run++;
                if (m_busy_run == TIMEOUT) begin
                    m_trap = 1; m_to = 1;
                end
            end else begin
                m_busy_run = 0;
                m_pend = 0;
                if (fl) m_flush = sat_inc(m_flush);
                else if (bub) m_stall = sat_inc(m_stall);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r);
        step(r, 32'h0000_0013, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle; compare away from the edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
                 ex_mem_hold, mem_timeout} !== e.ctl) begin
                failures++;
                $display("FAIL ctl t=%0t got=%b want=%b", $time,
                         {pc_write, if_id_write, id_ex_bubble, if_id_flush,
                          id_ex_flush, ex_mem_hold, mem_timeout}, e.ctl);
            end
            checks++;
            if (stall_cnt !== e.stall) begin
                failures++;
                $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.stall);
            end
            checks++;
            if (flush_cnt !== e.flush) begin
                failures++;
                $display("FAIL flush_cnt t=%0t got=%0d want=%0d", $time, flush_cnt, e.flush);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] add_x5;
        logic [6:0]  ops[8];
        add_x5 = mk(7'b0110011, 5'd5, 5'd7);
        ops[0] = 7'b0000011; ops[1] = 7'b0010011; ops[2] = 7'b0110011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1100111;
        ops[6] = 7'b0110111; ops[7] = 7'b1101111;
        reset = 1; id_inst = 0; id_valid = 0; ex_mem_read = 0; ex_rd = 0;
        ex_redirect = 0; mem_busy = 0;
        @(posedge clk); #1;
        idle(1); idle(1); idle(0);

        // Load-use on x5, then bubble in EX: one stall only.
        step(0, add_x5, 1, 1, 5'd5, 0, 0);
        step(0, add_x5, 1, 0, 5'd5, 0, 0);
        idle(0);
        // x0 destination and LUI (no sources) do not stall.
        step(0, mk(7'b0110011, 5'd0, 5'd7), 1, 1, 5'd0, 0, 0);
        step(0, mk(7'b0110111, 5'd5, 5'd5), 1, 1, 5'd5, 0, 0);
        // rs2 match and invalid ID instruction.
        step(0, mk(7'b0100011, 5'd1, 5'd5), 1, 1, 5'd5, 0, 0);
        step(0, add_x5, 0, 1, 5'd5, 0, 0);
        // Redirect coincident with load-use: flush only.
        step(0, add_x5, 1, 1, 5'd5, 1, 0);
        idle(0);

        // Freeze 3 cycles, redirect in 2nd; release flushes exactly once.
        idle(1); idle(0);
        step(0, 32'h13, 1, 0, 5'd0, 0, 1);
        step(0, 32'h13, 1, 0, 5'd0, 1, 1);
        step(0, 32'h13, 1, 0, 5'd0, 0, 1);
        idle(0); idle(0); idle(0);

        // Timeout trap after TIMEOUT busy cycles; sticky; reset clears.
        idle(1); idle(0);
        repeat (6) step(0, 32'h13, 1, 0, 5'd0, 1, 1);
        repeat (3) step(0, add_x5, 1, 1, 5'd5, 1, 0);
        idle(1); idle(0); idle(0);

        // Stall counter saturation.
        repeat (SAT + 6) step(0, add_x5, 1, 1, 5'd5, 0, 0);
        idle(0); idle(0);
        repeat (SAT + 3) step(0, 32'h13, 1, 0, 5'd0, 1, 0);
        idle(0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            ins = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)));
            step($urandom_range(0, 59) == 0, ins, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
        end
        idle(0);

        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain left=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
